// File: rtl/alu_op_issuer.sv
// ----------------------------------------------------------------------------
// alu_op_issuer
//
// Requester-side front end for the 32-bit combinational ALU. One operation is
// accepted at a time over a valid/ready handshake. Its operands and opcode are
// registered onto the ALU inputs. After LAT cycles the ALU result and flags are
// captured and held on a valid/ready response port until the consumer takes
// them.
//
// Parameters:
//   LAT         cycles from request accept to result sample, 1..15
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   req_valid   request present
//   req_ready   issuer can accept (IDLE only, low while in reset)
//   req_op      6-bit ALU opcode
//   req_a/b     32-bit operands
//   alu_a/b     registered operands driven to the ALU
//   alu_op      registered opcode, zero-extended to 32 bits
//   alu_result  ALU result
//   alu_z/n/c/v ALU flags
//   rsp_valid   response present
//   rsp_ready   consumer takes the response
//   rsp_result  captured result
//   rsp_flags   captured flags {Z,N,C,V}
//   rsp_err     illegal opcode indication
//   busy        high in any state other than IDLE
//
// Optional feature macro: ALU_ISSUE_OPCHK_EN
//   Defined:   opcodes above 0x0B are accepted without touching the ALU
//              registers and answered one cycle later with rsp_err=1 and
//              zero result/flags.
//   Undefined: every opcode is forwarded unchanged, rsp_err is constant 0.
// ----------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy
);

    generate
        if (LAT < 1 || LAT > 15) begin : g_lat_check
            $error("alu_op_issuer: LAT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    // req_ready is registered separately from the state so that it reads 0
    // while reset is held, without any path from the reset input to it.
    logic        rdy_q, rdy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] res_q, res_d;
    logic [3:0]  flags_q, flags_d;

`ifdef ALU_ISSUE_OPCHK_EN
    // bad_q marks an accepted illegal opcode: the EXEC visit that follows
    // answers with an error instead of waiting for the ALU.
    logic        bad_q, bad_d;
    logic        err_q, err_d;
    logic        bad_op;
    assign bad_op = (req_op > 6'h0B);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 6'd0;
            res_q   <= 32'd0;
            flags_q <= 4'd0;
`ifdef ALU_ISSUE_OPCHK_EN
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flags_q <= flags_d;
`ifdef ALU_ISSUE_OPCHK_EN
            bad_q   <= bad_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flags_d = flags_q;
`ifdef ALU_ISSUE_OPCHK_EN
        bad_d   = bad_q;
        err_d   = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (rdy_q && req_valid) begin
                    state_d = ST_EXEC;
                    cnt_d   = CNT_INIT;
`ifdef ALU_ISSUE_OPCHK_EN
                    bad_d   = bad_op;
                    if (!bad_op) begin
                        a_d  = req_a;
                        b_d  = req_b;
                        op_d = req_op;
                    end
`else
                    a_d  = req_a;
                    b_d  = req_b;
                    op_d = req_op;
`endif
                end
            end

            ST_EXEC: begin
`ifdef ALU_ISSUE_OPCHK_EN
                if (bad_q) begin
                    res_d   = 32'd0;
                    flags_d = 4'd0;
                    err_d   = 1'b1;
                    bad_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == 4'd0) begin
                    res_d   = alu_result;
                    flags_d = {alu_z, alu_n, alu_c, alu_v};
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
`else
                if (cnt_q == 4'd0) begin
                    res_d   = alu_result;
                    flags_d = {alu_z, alu_n, alu_c, alu_v};
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
`endif
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rdy_d = (state_d == ST_IDLE);

    assign req_ready  = rdy_q;
    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = {26'd0, op_q};
    assign rsp_result = res_q;
    assign rsp_flags  = flags_q;
`ifdef ALU_ISSUE_OPCHK_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// ----------------------------------------------------------------------------
// tb_alu_op_issuer
//
// Three issuers (LAT = 1, 4, 8) share clock, reset, operands and rsp_ready;
// each has its own req_valid. A behavioural ALU model drives each issuer's
// ALU inputs; the LAT=4 instance can be forced to output garbage to show that
// only the sample edge matters. Directed vectors with hand-computed results.
// ----------------------------------------------------------------------------
module tb_alu_op_issuer;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid_v;
    logic [5:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_ready;
    logic        garbage;

    logic [2:0]        req_ready_w;
    logic [2:0][31:0]  alu_a_w;
    logic [2:0][31:0]  alu_b_w;
    logic [2:0][31:0]  alu_op_w;
    logic [2:0][31:0]  alu_result_w;
    logic [2:0][3:0]   alu_flags_w;
    logic [2:0]        rsp_valid_w;
    logic [2:0][31:0]  rsp_result_w;
    logic [2:0][3:0]   rsp_flags_w;
    logic [2:0]        rsp_err_w;
    logic [2:0]        busy_w;

    int tests_run;
    int tests_failed;

    function automatic logic [31:0] alu_model(input logic [31:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        case (op)
            32'h0:   r = a;
            32'h1:   r = b;
            32'h2:   r = a & b;
            32'h3:   r = a | b;
            32'h4:   r = a ^ b;
            32'h5:   r = ~(a ^ b);
            32'h6:   r = ~a;
            32'h7:   r = ~b;
            32'h8:   r = a << b[4:0];
            32'h9:   r = a >> b[4:0];
            32'hA:   r = $unsigned($signed(a) >>> b[4:0]);
            32'hB:   r = {b[15:0], 16'h0000};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Bench ALU flags: Z, N, C = r[31]^r[0], V = r[1] (distinct per bit so
    // the {Z,N,C,V} ordering is observable).
    function automatic logic [3:0] flag_model(input logic [31:0] r);
        return {(r == 32'h0), r[31], r[31] ^ r[0], r[1]};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);
            assign alu_result_w[gi] = (gi == 1 && garbage) ? 32'hDEADBEEF
                                    : alu_model(alu_op_w[gi], alu_a_w[gi], alu_b_w[gi]);
            assign alu_flags_w[gi]  = (gi == 1 && garbage) ? 4'hF
                                    : flag_model(alu_result_w[gi]);
            alu_op_issuer #(.LAT(L)) u_dut (
                .clk        (clk),
                .reset      (reset),
                .req_valid  (req_valid_v[gi]),
                .req_ready  (req_ready_w[gi]),
                .req_op     (req_op),
                .req_a      (req_a),
                .req_b      (req_b),
                .alu_a      (alu_a_w[gi]),
                .alu_b      (alu_b_w[gi]),
                .alu_op     (alu_op_w[gi]),
                .alu_result (alu_result_w[gi]),
                .alu_z      (alu_flags_w[gi][3]),
                .alu_n      (alu_flags_w[gi][2]),
                .alu_c      (alu_flags_w[gi][1]),
                .alu_v      (alu_flags_w[gi][0]),
                .rsp_valid  (rsp_valid_w[gi]),
                .rsp_ready  (rsp_ready),
                .rsp_result (rsp_result_w[gi]),
                .rsp_flags  (rsp_flags_w[gi]),
                .rsp_err    (rsp_err_w[gi]),
                .busy       (busy_w[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; all driving and sampling happen here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid_v = 3'b111; rsp_ready = 1'b0; garbage = 1'b0;
        req_a = 32'hFFFFFFFF; req_b = 32'hFFFFFFFF; req_op = 6'h03;
        step(); step();
        tests_run++; if (req_ready_w !== 3'b000) begin tests_failed++; $display("FAIL rst_req_ready: got %b expected 000", req_ready_w); end
        tests_run++; if (busy_w !== 3'b000) begin tests_failed++; $display("FAIL rst_busy: got %b expected 000", busy_w); end
        tests_run++; if (rsp_valid_w !== 3'b000) begin tests_failed++; $display("FAIL rst_rsp_valid: got %b expected 000", rsp_valid_w); end
        tests_run++; if (alu_a_w[0] !== 32'h0 || alu_b_w[0] !== 32'h0 || alu_op_w[0] !== 32'h0) begin tests_failed++; $display("FAIL rst_alu: got a=%h b=%h op=%h expected all 0", alu_a_w[0], alu_b_w[0], alu_op_w[0]); end
        tests_run++; if (rsp_result_w[0] !== 32'h0 || rsp_flags_w[0] !== 4'h0 || rsp_err_w[0] !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_data: got res=%h flags=%h err=%b expected 0", rsp_result_w[0], rsp_flags_w[0], rsp_err_w[0]); end
        reset = 1'b0;
        step();
        tests_run++; if (req_ready_w !== 3'b111) begin tests_failed++; $display("FAIL rel_req_ready: got %b expected 111", req_ready_w); end
        tests_run++; if (busy_w !== 3'b000 || alu_a_w[0] !== 32'h0) begin tests_failed++; $display("FAIL rel_no_accept: got busy=%b alu_a=%h expected 000/0", busy_w, alu_a_w[0]); end
        req_valid_v = 3'b000;
        $display("[TB] reset: released, req_ready=%b", req_ready_w);
    endtask

    task automatic test_and();
        req_a = 32'hACDFFF5A; req_b = 32'h0000FFFF; req_op = 6'h02; req_valid_v = 3'b001;
        step();
        req_valid_v = 3'b000;
        tests_run++; if (alu_op_w[0] !== 32'h00000002 || alu_a_w[0] !== 32'hACDFFF5A || alu_b_w[0] !== 32'h0000FFFF) begin tests_failed++; $display("FAIL and_issue: got a=%h b=%h op=%h", alu_a_w[0], alu_b_w[0], alu_op_w[0]); end
        tests_run++; if (busy_w[0] !== 1'b1 || req_ready_w[0] !== 1'b0 || rsp_valid_w[0] !== 1'b0) begin tests_failed++; $display("FAIL and_exec: got busy=%b ready=%b rv=%b expected 1/0/0", busy_w[0], req_ready_w[0], rsp_valid_w[0]); end
        step();
        tests_run++; if (rsp_valid_w[0] !== 1'b1 || busy_w[0] !== 1'b1) begin tests_failed++; $display("FAIL and_rsp_valid: got rv=%b busy=%b expected 1/1", rsp_valid_w[0], busy_w[0]); end
        tests_run++; if (rsp_result_w[0] !== 32'h0000FF5A || rsp_flags_w[0] !== 4'b0001 || rsp_err_w[0] !== 1'b0) begin tests_failed++; $display("FAIL and_rsp_data: got res=%h flags=%b err=%b expected 0000ff5a/0001/0", rsp_result_w[0], rsp_flags_w[0], rsp_err_w[0]); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        tests_run++; if (rsp_valid_w[0] !== 1'b0 || req_ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin tests_failed++; $display("FAIL and_idle: got rv=%b ready=%b busy=%b expected 0/1/0", rsp_valid_w[0], req_ready_w[0], busy_w[0]); end
        tests_run++; if (rsp_result_w[0] !== 32'h0000FF5A || alu_a_w[0] !== 32'hACDFFF5A) begin tests_failed++; $display("FAIL and_hold: got res=%h alu_a=%h", rsp_result_w[0], alu_a_w[0]); end
        $display("[TB] AND LAT=1: result=%h flags=%b", rsp_result_w[0], rsp_flags_w[0]);
    endtask

    task automatic test_back_to_back();
        int bad;
        req_a = 32'hF0F0F0F0; req_b = 32'hFFFF0000; req_op = 6'h04; req_valid_v = 3'b001;
        step();
        // Second request stays pending on the same valid line.
        req_a = 32'h12340000; req_b = 32'h00005678; req_op = 6'h03;
        step();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_valid_w[0] !== 1'b1 || rsp_result_w[0] !== 32'h0F0FF0F0 || req_ready_w[0] !== 1'b0 || alu_a_w[0] !== 32'hF0F0F0F0) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL bp_stable: got %0d unstable cycles expected 0 (last rv=%b res=%h)", bad, rsp_valid_w[0], rsp_result_w[0]); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        tests_run++; if (rsp_valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin tests_failed++; $display("FAIL bp_handshake: got rv=%b busy=%b expected 0/0", rsp_valid_w[0], busy_w[0]); end
        step();
        req_valid_v = 3'b000;
        tests_run++; if (busy_w[0] !== 1'b1 || alu_a_w[0] !== 32'h12340000 || alu_op_w[0] !== 32'h3) begin tests_failed++; $display("FAIL bp_second_accept: got busy=%b a=%h op=%h expected 1/12340000/3", busy_w[0], alu_a_w[0], alu_op_w[0]); end
        step();
        tests_run++; if (rsp_valid_w[0] !== 1'b1 || rsp_result_w[0] !== 32'h12345678 || rsp_flags_w[0] !== 4'b0000) begin tests_failed++; $display("FAIL bp_second_rsp: got rv=%b res=%h flags=%b expected 1/12345678/0000", rsp_valid_w[0], rsp_result_w[0], rsp_flags_w[0]); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        $display("[TB] backpressure: first=0f0ff0f0 second=%h", rsp_result_w[0]);
    endtask

    task automatic test_sra_lat4();
        int bad;
        garbage = 1'b1;
        req_a = 32'h80000000; req_b = 32'h00000004; req_op = 6'h0A; req_valid_v = 3'b010;
        step();
        req_valid_v = 3'b000;
        bad = 0;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (rsp_valid_w[1] !== 1'b0 || busy_w[1] !== 1'b1) bad++;
            if (k == 3) garbage = 1'b0;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL sra_early: got %0d early/idle cycles expected 0", bad); end
        step();
        tests_run++; if (rsp_valid_w[1] !== 1'b1 || rsp_result_w[1] !== 32'hF8000000 || rsp_flags_w[1] !== 4'b0110) begin tests_failed++; $display("FAIL sra_rsp: got rv=%b res=%h flags=%b expected 1/f8000000/0110", rsp_valid_w[1], rsp_result_w[1], rsp_flags_w[1]); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        tests_run++; if (req_ready_w[1] !== 1'b1 || rsp_valid_w[1] !== 1'b0) begin tests_failed++; $display("FAIL sra_idle: got ready=%b rv=%b expected 1/0", req_ready_w[1], rsp_valid_w[1]); end
        $display("[TB] SRA LAT=4: result=%h flags=%b", rsp_result_w[1], rsp_flags_w[1]);
    endtask

    task automatic test_illegal_op();
        req_a = 32'h55555555; req_b = 32'hAAAAAAAA; req_op = 6'h20; req_valid_v = 3'b001;
        step();
        req_valid_v = 3'b000;
`ifdef ALU_ISSUE_OPCHK_EN
        tests_run++; if (alu_op_w[0] !== 32'h3 || alu_a_w[0] !== 32'h12340000 || alu_b_w[0] !== 32'h00005678) begin tests_failed++; $display("FAIL ill_alu_hold: got a=%h b=%h op=%h", alu_a_w[0], alu_b_w[0], alu_op_w[0]); end
        step();
        tests_run++; if (rsp_valid_w[0] !== 1'b1 || rsp_err_w[0] !== 1'b1 || rsp_result_w[0] !== 32'h0 || rsp_flags_w[0] !== 4'h0) begin tests_failed++; $display("FAIL ill_rsp: got rv=%b err=%b res=%h flags=%b expected 1/1/0/0", rsp_valid_w[0], rsp_err_w[0], rsp_result_w[0], rsp_flags_w[0]); end
`else
        tests_run++; if (alu_op_w[0] !== 32'h20 || alu_a_w[0] !== 32'h55555555) begin tests_failed++; $display("FAIL ill_forward: got a=%h op=%h expected 55555555/20", alu_a_w[0], alu_op_w[0]); end
        step();
        tests_run++; if (rsp_valid_w[0] !== 1'b1 || rsp_err_w[0] !== 1'b0 || rsp_result_w[0] !== 32'h0 || rsp_flags_w[0] !== 4'b1000) begin tests_failed++; $display("FAIL ill_rsp: got rv=%b err=%b res=%h flags=%b expected 1/0/0/1000", rsp_valid_w[0], rsp_err_w[0], rsp_result_w[0], rsp_flags_w[0]); end
`endif
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        $display("[TB] opcode 0x20: err=%b result=%h", rsp_err_w[0], rsp_result_w[0]);
    endtask

    task automatic test_reset_mid_exec();
        int seen;
        req_a = 32'h11111111; req_b = 32'h22222222; req_op = 6'h00; req_valid_v = 3'b100;
        step();
        req_valid_v = 3'b000;
        tests_run++; if (busy_w[2] !== 1'b1 || alu_a_w[2] !== 32'h11111111) begin tests_failed++; $display("FAIL mid_accept: got busy=%b a=%h expected 1/11111111", busy_w[2], alu_a_w[2]); end
        step(); step();
        reset = 1'b1;
        step();
        tests_run++; if (busy_w[2] !== 1'b0 || rsp_valid_w[2] !== 1'b0 || req_ready_w[2] !== 1'b0 || alu_a_w[2] !== 32'h0 || alu_b_w[2] !== 32'h0 || alu_op_w[2] !== 32'h0) begin tests_failed++; $display("FAIL mid_reset: got busy=%b rv=%b ready=%b a=%h b=%h op=%h", busy_w[2], rsp_valid_w[2], req_ready_w[2], alu_a_w[2], alu_b_w[2], alu_op_w[2]); end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid_w[2] !== 1'b0 || busy_w[2] !== 1'b0) seen++;
        end
        tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL mid_no_rsp: got %0d cycles with rv/busy set expected 0", seen); end
        tests_run++; if (req_ready_w[2] !== 1'b1 || rsp_result_w[2] !== 32'h0) begin tests_failed++; $display("FAIL mid_idle: got ready=%b res=%h expected 1/0", req_ready_w[2], rsp_result_w[2]); end
        $display("[TB] reset mid-EXEC LAT=8: busy=%b rsp_valid=%b", busy_w[2], rsp_valid_w[2]);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_and();
        test_back_to_back();
        test_sra_lat4();
        test_illegal_op();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Requester-side front end for the 32-bit ALU. Accepts one operation request at a time over a valid/ready handshake and drives the ALU's `A`, `B` and `operation` inputs from registers. After a fixed settle latency it samples the ALU result and the Z/N/C/V flags, then holds them on a valid/ready response port until the consumer takes them. It sits between the instruction/control path and the combinational ALU, so every ALU transaction is launched from registered operands and captured into registers.

## Interface
- `LAT`, default 1: cycles from request accept to result sample; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  issuer can accept a request; asserted only in IDLE.
- `req_op`  in  6  ALU opcode, 0x00..0x0B: PASS A, PASS B, AND, OR, XOR, XNOR, ~A, ~B, SLL, SRL, SRA, LUI.
- `req_a`, `req_b`  in  32  operands.
- `alu_a`, `alu_b`  out  32  registered operands to the ALU.
- `alu_op`  out  32  registered opcode, zero-extended from 6 bits.
- `alu_result`  in  32  ALU `respuesta`.
- `alu_z`, `alu_n`, `alu_c`, `alu_v`  in  1  ALU flags.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_result`  out  32  captured result.
- `rsp_flags`  out  4  captured flags, ordered {Z,N,C,V}.
- `rsp_err`  out  1  illegal opcode; only when `ALU_ISSUE_OPCHK_EN` is defined, otherwise tied 0.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, EXEC, RESP. The reset state is IDLE.
- **IDLE**
  - `req_ready=1`.
  - On `req_valid`: load `alu_a←req_a`, `alu_b←req_b`, `alu_op←{26'b0,req_op}` and `cnt←LAT-1`, then go to EXEC.
- **EXEC**
  - `alu_*` are held constant and `req_ready=0`.
  - If `cnt≠0`, decrement.
  - If `cnt==0`: capture `rsp_result←alu_result`, `rsp_flags←{alu_z,alu_n,alu_c,alu_v}` and `rsp_err←0`, then go to RESP.
  - ALU input values seen before the sample edge are ignored.
- **RESP**
  - `rsp_valid=1`; `rsp_result`, `rsp_flags` and `rsp_err` are stable.
  - On `rsp_ready`, go to IDLE.
  - `rsp_valid` is never dropped without a handshake.
- **Between transactions:** `alu_*` keep the last issued values; they are not cleared in IDLE. `rsp_*` data also hold after the handshake; only `rsp_valid` falls.
- **Width rules:** pure capture, no arithmetic in this block. `cnt` is 4 bits. `LAT` outside 1..15 is a compile-time error via a generate-time check.
- **Simultaneous events:** `req_valid` during EXEC or RESP is not accepted; the request must be held by the source. A `rsp_ready` without `rsp_valid` is ignored.
- **Reset mid-operation:** any state goes to IDLE and the in-flight transaction is dropped with no response.

## Timing
- **Accept:** a request is accepted at edge t, where `req_valid & req_ready`. `alu_*` are valid from edge t.
- **Sample:** the result is sampled at edge t+LAT. `rsp_valid` is high from edge t+LAT.
- **Response latency:** LAT cycles from accept.
- **Throughput:** the earliest response handshake is edge t+LAT+1, which returns to IDLE. The next accept is at edge t+LAT+2 or later. Minimum issue interval is LAT+2 cycles.
- **Output decode:** `req_ready`, `rsp_valid` and `busy` are decoded from the state register; there are no combinational paths from inputs to outputs.
- **Reset values:**
  - during reset: `req_ready=0`;
  - from the first non-reset cycle: `req_ready=1`;
  - `busy=0`, `rsp_valid=0`, `rsp_result=0`, `rsp_flags=0`, `rsp_err=0`, `alu_a=0`, `alu_b=0`, `alu_op=0`.

## Configuration
- Macro: `ALU_ISSUE_OPCHK_EN`.
- **Defined:** in IDLE, a request with `req_op>0x0B` is accepted, but `alu_*` are not loaded. The FSM goes directly to RESP on the next edge with `rsp_result=0`, `rsp_flags=0`, `rsp_err=1`. Response latency is 1 cycle regardless of LAT.
- **Undefined:** all opcodes are forwarded to the ALU unchanged and `rsp_err` is constant 0.

## Test plan
1. **Reset:** hold `reset` for 2 cycles with `req_valid=1`, then release.
   - No accept occurs during reset; every output is at its reset value.
   - `req_ready=1` on the first cycle after release.
2. **AND, LAT=1:** `req_a=0xACDFFF5A`, `req_b=0x0000FFFF`, `req_op=0x02`.
   - After the accept edge: `alu_op=0x00000002`.
   - One edge later: `rsp_valid=1`, `rsp_result=0x0000FF5A` from the bench ALU model, `busy=1`.
   - After `rsp_ready`: back to IDLE.
3. **Backpressure:** hold `rsp_ready=0` for 5 cycles while a second request is pending.
   - `rsp_valid` and `rsp_result` are stable for all 5 cycles; `req_ready=0`.
   - The second request is accepted exactly 1 cycle after the handshake.
4. **LAT=4, SRA:** `req_a=0x80000000`, `req_b=4`, `req_op=0x0A`.
   - The bench ALU model outputs garbage until cycle 3.
   - `rsp_valid` rises exactly 4 cycles after accept, with `rsp_result=0xF8000000`.
5. **Illegal opcode, `ALU_ISSUE_OPCHK_EN` defined:** `req_op=0x20`.
   - `rsp_err=1`, `rsp_result=0`, response 1 cycle after accept.
   - `alu_*` retain the previous values.
6. **Reset mid-EXEC:** LAT=8; assert `reset` 3 cycles after accept.
   - `rsp_valid` never rises.
   - FSM returns to IDLE with all outputs at reset values.
